// File: rtl/soft_rst_ctrl.sv
// Keyed soft-reset request generator: a KEY1/KEY2 unlock sequence produces a fixed-width
// active-low soft_rst pulse, followed by a hold-off window that blocks re-triggering.
module soft_rst_ctrl #(
  parameter logic [15:0] KEY1           = 16'h5A5A,
  parameter logic [15:0] KEY2           = 16'hA5A5,
  parameter int unsigned ARM_TIMEOUT    = 1000,
  parameter int unsigned PULSE_CYCLES   = 32,
  parameter int unsigned HOLDOFF_CYCLES = 256
) (
  input  logic        clk_125m,
  input  logic        rst_125m,
  input  logic        reg_wr_en,
  input  logic [15:0] reg_wr_data,
  output logic        soft_rst,
  output logic        armed,
  output logic        busy,
  output logic        key_err,
  output logic [7:0]  rst_req_cnt
);

  localparam logic [15:0] ARM_LAST   = 16'(ARM_TIMEOUT - 1);
  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF_CYCLES - 1);

  // Identical keys would let a single word unlock and fire; reject at elaboration.
  if (KEY1 == KEY2) begin : g_key_check
    $error("soft_rst_ctrl: KEY1 and KEY2 must differ");
  end
  if (ARM_TIMEOUT < 1 || ARM_TIMEOUT > 65535 || PULSE_CYCLES < 1 || PULSE_CYCLES > 65535 ||
      HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 65535) begin : g_range_check
    $error("soft_rst_ctrl: cycle parameters must lie in 1..65535");
  end

  typedef enum logic [1:0] {StIdle, StArmed, StPulse, StHoldoff} state_e;

  state_e      r_state, w_state_d;
  logic [15:0] r_timer, w_timer_d;
  logic        w_restart;
  logic        w_key_err_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic        r_soft_rst, r_armed, r_busy, r_key_err;

  always_comb begin
    w_state_d   = r_state;
    w_restart   = 1'b0;
    w_key_err_d = 1'b0;
    w_cnt_d     = r_cnt;
    case (r_state)
      StIdle: begin
        if (reg_wr_en) begin
          if (reg_wr_data == KEY1) w_state_d = StArmed;
          else                     w_key_err_d = 1'b1;
        end
      end
      StArmed: begin
        // A write in the timeout cycle takes priority over the timeout.
        if (reg_wr_en) begin
          if (reg_wr_data == KEY2) begin
            w_state_d = StPulse;
            if (r_cnt != 8'hFF) w_cnt_d = r_cnt + 8'd1;
          end else if (reg_wr_data == KEY1) begin
            w_restart = 1'b1;
          end else begin
            w_state_d   = StIdle;
            w_key_err_d = 1'b1;
          end
        end else if (r_timer == ARM_LAST) begin
          w_state_d = StIdle;
        end
      end
      StPulse: begin
        if (r_timer == PULSE_LAST) w_state_d = StHoldoff;
      end
      StHoldoff: begin
        if (r_timer == HOLD_LAST) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    if (w_state_d != r_state || w_restart || r_state == StIdle) w_timer_d = 16'd0;
    else                                                       w_timer_d = r_timer + 16'd1;
  end

  always_ff @(posedge clk_125m) begin
    if (rst_125m) begin
      r_state    <= StIdle;
      r_timer    <= 16'd0;
      r_soft_rst <= 1'b1;
      r_armed    <= 1'b0;
      r_busy     <= 1'b0;
      r_key_err  <= 1'b0;
      r_cnt      <= 8'd0;
    end else begin
      r_state    <= w_state_d;
      r_timer    <= w_timer_d;
      r_soft_rst <= (w_state_d != StPulse);
      r_armed    <= (w_state_d == StArmed);
      r_busy     <= (w_state_d == StPulse) || (w_state_d == StHoldoff);
      r_key_err  <= w_key_err_d;
      r_cnt      <= w_cnt_d;
    end
  end

  assign soft_rst    = r_soft_rst;
  assign armed       = r_armed;
  assign busy        = r_busy;
  assign key_err     = r_key_err;
  assign rst_req_cnt = r_cnt;

endmodule

// File: tb/tb_soft_rst_ctrl.sv
// Bench for soft_rst_ctrl: a timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized write phase.
module tb_soft_rst_ctrl;

  localparam logic [15:0] KEY1 = 16'h5A5A;
  localparam logic [15:0] KEY2 = 16'hA5A5;
  localparam longint A_TO  = 1000;
  localparam longint P_CYC = 32;
  localparam longint H_CYC = 256;

  logic        clk_125m = 1'b0;
  logic        rst_125m = 1'b1;
  logic        reg_wr_en = 1'b0;
  logic [15:0] reg_wr_data = 16'h0000;
  logic        soft_rst, armed, busy, key_err;
  logic [7:0]  rst_req_cnt;

  soft_rst_ctrl dut (
    .clk_125m   (clk_125m),
    .rst_125m   (rst_125m),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_data(reg_wr_data),
    .soft_rst   (soft_rst),
    .armed      (armed),
    .busy       (busy),
    .key_err    (key_err),
    .rst_req_cnt(rst_req_cnt)
  );

  always #4 clk_125m = ~clk_125m;

  int n_chk  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: each output is a function of edge index t and the last edge of each window.
  longint t = 0;
  longint arm_last = -1, pulse_last = -1, busy_last = -1;
  int     m_cnt = 0;
  int     exp_soft_rst = 1, exp_armed = 0, exp_busy = 0, exp_kerr = 0;

  initial forever begin
    @(posedge clk_125m);
    t++;
    exp_kerr = 0;
    if (rst_125m) begin
      arm_last = -1; pulse_last = -1; busy_last = -1; m_cnt = 0;
    end else if (t - 1 <= busy_last) begin
      // pulse or hold-off in progress: writes ignored
    end else if (reg_wr_en) begin
      if (t - 1 <= arm_last) begin
        if (reg_wr_data == KEY2) begin
          pulse_last = t + P_CYC - 1;
          busy_last  = t + P_CYC + H_CYC - 1;
          arm_last   = t - 1;
          if (m_cnt < 255) m_cnt++;
        end else if (reg_wr_data == KEY1) begin
          arm_last = t + A_TO - 1;
        end else begin
          arm_last = t - 1;
          exp_kerr = 1;
        end
      end else if (reg_wr_data == KEY1) begin
        arm_last = t + A_TO - 1;
      end else begin
        exp_kerr = 1;
      end
    end
    exp_armed    = (t <= arm_last) ? 1 : 0;
    exp_busy     = (t <= busy_last) ? 1 : 0;
    exp_soft_rst = (t <= pulse_last) ? 0 : 1;
  end

  int n_low = 0, n_busy = 0, n_armed = 0, n_kerr = 0;

  initial forever begin
    @(negedge clk_125m);
    if (check_en) begin
      chk("soft_rst", 32'(soft_rst), exp_soft_rst);
      chk("armed", 32'(armed), exp_armed);
      chk("busy", 32'(busy), exp_busy);
      chk("key_err", 32'(key_err), exp_kerr);
      chk("rst_req_cnt", 32'(rst_req_cnt), m_cnt);
      n_low   += soft_rst ? 0 : 1;
      n_busy  += busy ? 1 : 0;
      n_armed += armed ? 1 : 0;
      n_kerr  += key_err ? 1 : 0;
    end
  end

  task automatic clr();
    n_low = 0; n_busy = 0; n_armed = 0; n_kerr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_125m);
    #1;
  endtask

  // Write is sampled at the next edge; returns 1 ns after that edge.
  task automatic wr(input logic [15:0] d);
    reg_wr_en   = 1'b1;
    reg_wr_data = d;
    @(posedge clk_125m);
    #1;
    reg_wr_en   = 1'b0;
    reg_wr_data = 16'($urandom);
  endtask

  initial begin
    // reset state
    idle(3);
    rst_125m = 1'b0;
    check_en = 1'b1;
    chk("rst_soft_rst", 32'(soft_rst), 1);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_key_err", 32'(key_err), 0);
    chk("rst_cnt", 32'(rst_req_cnt), 0);

    // 1: basic unlock and pulse
    wr(KEY1);
    idle(4);
    clr();
    wr(KEY2);
    chk("t1_first_low", 32'(soft_rst), 0);
    idle(300);
    chk("t1_low_width", n_low, 32);
    chk("t1_busy_width", n_busy, 288);
    chk("t1_cnt", 32'(rst_req_cnt), 1);

    // 2: silent timeout, then KEY2 while idle is a bad word
    wr(KEY1);
    clr();
    idle(1100);
    chk("t2_armed_width", n_armed, 1000);
    chk("t2_no_kerr", n_kerr, 0);
    clr();
    wr(KEY2);
    chk("t2_kerr", 32'(key_err), 1);
    idle(2);
    chk("t2_kerr_width", n_kerr, 1);
    chk("t2_no_pulse", n_low, 0);

    // 3: bad word while armed; KEY1 re-arm restarts the timeout
    wr(KEY1);
    idle(3);
    wr(16'h1234);
    chk("t3_kerr", 32'(key_err), 1);
    chk("t3_disarmed", 32'(armed), 0);
    idle(1);
    chk("t3_kerr_one_cycle", 32'(key_err), 0);
    wr(KEY1);
    idle(900);
    wr(KEY1);
    idle(900);
    clr();
    wr(KEY2);
    idle(300);
    chk("t3_rearm_pulse", n_low, 32);
    chk("t3_cnt", 32'(rst_req_cnt), 2);

    // 4: sequence during hold-off is ignored
    wr(KEY1);
    wr(KEY2);
    idle(40);
    clr();
    wr(KEY1);
    wr(KEY2);
    idle(300);
    chk("t4_holdoff_no_pulse", n_low, 0);
    chk("t4_holdoff_no_kerr", n_kerr, 0);
    chk("t4_cnt", 32'(rst_req_cnt), 3);

    // 4b: saturation, with random writes thrown at the hold-off window
    for (int k = 0; k < 254; k++) begin
      wr(KEY1);
      idle($urandom_range(0, 2));
      wr(KEY2);
      for (int i = 0; i < 288; i++) begin
        if ($urandom_range(0, 15) == 0) wr(($urandom_range(0, 1) == 0) ? KEY1 : KEY2);
        else idle(1);
      end
    end
    chk("t4_saturated", 32'(rst_req_cnt), 255);

    // 5: reset during the 10th low cycle
    wr(KEY1);
    wr(KEY2);
    idle(9);
    chk("t5_still_low", 32'(soft_rst), 0);
    rst_125m = 1'b1;
    idle(1);
    rst_125m = 1'b0;
    chk("t5_soft_rst", 32'(soft_rst), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_cnt", 32'(rst_req_cnt), 0);
    chk("t5_armed", 32'(armed), 0);

    // 6: KEY2 in the last armed cycle wins over the timeout
    wr(KEY1);
    idle(999);
    chk("t6_still_armed", 32'(armed), 1);
    clr();
    wr(KEY2);
    idle(300);
    chk("t6_pulse", n_low, 32);
    chk("t6_cnt", 32'(rst_req_cnt), 1);
    chk("t6_no_kerr", n_kerr, 0);

    // randomized phase, checked by the model only
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       wr(KEY1);
          1:       wr(KEY2);
          default: wr(16'($urandom));
        endcase
      end else begin
        idle(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
